// File: rtl/ram_read_checker.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : ram_read_checker                                             |
// | Description : Read-side checker for the dual-port RAM write controller.    |
// |               Sweeps port B from address 0 to DEPTH-1, compares each word  |
// |               against the incrementing pattern (START_VAL + k) mod         |
// |               2**DATA_W, and reports a saturating mismatch count plus a    |
// |               pass flag.                                                   |
// | Ports       : rdclk      - clock, rising edge                              |
// |               rst        - synchronous active-high reset                   |
// |               start      - 1-cycle pulse, starts a sweep when idle         |
// |               address_b  - RAM port-B address                              |
// |               rden_b     - RAM port-B read enable                          |
// |               wren_b     - RAM port-B write enable (tied low)              |
// |               q_b        - RAM port-B read data                            |
// |               busy       - sweep in progress                               |
// |               done       - 1-cycle pulse at end of sweep                   |
// |               pass       - last sweep had zero mismatches                  |
// |               err_cnt    - mismatch count, saturating                      |
// | Option      : FIRST_ERR_CAPTURE_EN adds first_err_vld / first_err_addr /   |
// |               first_err_data, latching the first mismatch of a sweep.      |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module ram_read_checker #(
  parameter int ADDR_W    = 10,
  parameter int DATA_W    = 8,
  parameter int DEPTH     = 1024,
  parameter int RD_LAT    = 2,
  parameter int START_VAL = 0
) (
  input  logic              rdclk,
  input  logic              rst,
  input  logic              start,
  output logic [ADDR_W-1:0] address_b,
  output logic              rden_b,
  output logic              wren_b,
  input  logic [DATA_W-1:0] q_b,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [ADDR_W:0]   err_cnt
`ifdef FIRST_ERR_CAPTURE_EN
  ,
  output logic              first_err_vld,
  output logic [ADDR_W-1:0] first_err_addr,
  output logic [DATA_W-1:0] first_err_data
`endif
);

  localparam logic [ADDR_W-1:0] c_LAST_ADDR  = ADDR_W'(DEPTH - 1);
  localparam logic [ADDR_W-1:0] c_ADDR_ONE   = ADDR_W'(1);
  localparam logic [DATA_W-1:0] c_START      = DATA_W'(START_VAL);
  localparam logic [ADDR_W:0]   c_ERR_MAX    = '1;
  localparam logic [ADDR_W:0]   c_ERR_ONE    = (ADDR_W+1)'(1);
  localparam logic [1:0]        c_DRAIN_LAST = 2'(RD_LAT - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_READ  = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic                w_start_acc;
  logic [ADDR_W-1:0]   r_addr;
  logic                r_rden;
  logic [1:0]          r_drain_cnt;
  logic                r_busy;
  logic                r_done;
  logic                r_pass;
  logic [ADDR_W:0]     r_err;

  // Compare pipeline: entry 0 is captured from the address currently on the
  // pins, so the tail entry lines up with q_b exactly RD_LAT cycles later.
  logic [RD_LAT-1:0]   r_pv;
  logic [DATA_W-1:0]   r_pe [RD_LAT];
  logic [DATA_W-1:0]   w_exp_push;
  logic                w_mismatch;

  // Expected word for the address on the pins; the add wraps at 2**DATA_W so
  // the pattern repeats when DEPTH exceeds the data range.
  assign w_exp_push = c_START + DATA_W'(r_addr);
  assign w_mismatch = r_pv[RD_LAT-1] && (q_b != r_pe[RD_LAT-1]);

  always_comb begin
    w_state_nxt = r_state;
    w_start_acc = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_state_nxt = S_READ;
          w_start_acc = 1'b1;
        end
      end
      S_READ: begin
        if (r_addr == c_LAST_ADDR) begin
          w_state_nxt = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (r_drain_cnt == c_DRAIN_LAST) begin
          w_state_nxt = S_DONE;
        end
      end
      S_DONE: begin
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge rdclk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_addr      <= '0;
      r_rden      <= 1'b0;
      r_drain_cnt <= '0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_pass      <= 1'b0;
      r_err       <= '0;
    end else begin
      r_state <= w_state_nxt;

      if (w_start_acc) begin
        r_addr <= '0;
        r_rden <= 1'b1;
      end else if (r_state == S_READ) begin
        if (r_addr == c_LAST_ADDR) begin
          r_addr <= '0;
          r_rden <= 1'b0;
        end else begin
          r_addr <= r_addr + c_ADDR_ONE;
        end
      end

      if (r_state == S_DRAIN) begin
        r_drain_cnt <= r_drain_cnt + 2'd1;
      end else begin
        r_drain_cnt <= '0;
      end

      // Status outputs are registered: what the DONE state decides is seen on
      // the pins in the cycle that follows it.
      r_done <= (r_state == S_DONE);
      if (w_start_acc) begin
        r_busy <= 1'b1;
        r_pass <= 1'b0;
      end else if (r_state == S_DONE) begin
        r_busy <= 1'b0;
        r_pass <= (r_err == '0);
      end

      // A start is only accepted in IDLE, when no compare can be pending.
      if (w_start_acc) begin
        r_err <= '0;
      end else if (w_mismatch && (r_err != c_ERR_MAX)) begin
        r_err <= r_err + c_ERR_ONE;
      end
    end
  end

  always_ff @(posedge rdclk) begin
    if (rst) begin
      r_pv <= '0;
      for (int i = 0; i < RD_LAT; i++) begin
        r_pe[i] <= '0;
      end
    end else begin
      r_pv[0] <= r_rden;
      r_pe[0] <= w_exp_push;
      for (int i = 1; i < RD_LAT; i++) begin
        r_pv[i] <= r_pv[i-1];
        r_pe[i] <= r_pe[i-1];
      end
    end
  end

`ifdef FIRST_ERR_CAPTURE_EN
  logic [ADDR_W-1:0] r_pa [RD_LAT];
  logic              r_fe_vld;
  logic [ADDR_W-1:0] r_fe_addr;
  logic [DATA_W-1:0] r_fe_data;

  always_ff @(posedge rdclk) begin
    if (rst) begin
      for (int i = 0; i < RD_LAT; i++) begin
        r_pa[i] <= '0;
      end
      r_fe_vld  <= 1'b0;
      r_fe_addr <= '0;
      r_fe_data <= '0;
    end else begin
      r_pa[0] <= r_addr;
      for (int i = 1; i < RD_LAT; i++) begin
        r_pa[i] <= r_pa[i-1];
      end
      if (w_start_acc) begin
        r_fe_vld  <= 1'b0;
        r_fe_addr <= '0;
        r_fe_data <= '0;
      end else if (w_mismatch && !r_fe_vld) begin
        r_fe_vld  <= 1'b1;
        r_fe_addr <= r_pa[RD_LAT-1];
        r_fe_data <= q_b;
      end
    end
  end

  assign first_err_vld  = r_fe_vld;
  assign first_err_addr = r_fe_addr;
  assign first_err_data = r_fe_data;
`endif

  assign address_b = r_addr;
  assign rden_b    = r_rden;
  assign wren_b    = 1'b0;
  assign busy      = r_busy;
  assign done      = r_done;
  assign pass      = r_pass;
  assign err_cnt   = r_err;

endmodule
`default_nettype wire
